// File: rtl/calc_cmd_scheduler_pkg.sv
// Shared command codes, source map, FSM encoding and small helpers for the
// calculator command scheduler.
package calc_cmd_scheduler_pkg;

  localparam int NUM_SRC = 9;
  localparam int CMD_W   = 4;

  localparam logic [CMD_W-1:0] CMD_CLEAR  = 4'd0;
  localparam logic [CMD_W-1:0] CMD_DIGIT1 = 4'd1;
  localparam logic [CMD_W-1:0] CMD_DIGIT2 = 4'd2;
  localparam logic [CMD_W-1:0] CMD_DIGIT3 = 4'd3;
  localparam logic [CMD_W-1:0] CMD_DIGIT4 = 4'd4;
  localparam logic [CMD_W-1:0] CMD_ADD    = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SUB    = 4'd6;
  localparam logic [CMD_W-1:0] CMD_MUL    = 4'd7;
  localparam logic [CMD_W-1:0] CMD_DIV    = 4'd8;

  // Pending bits owned by arithmetic ops; a clear command also discards these.
  localparam logic [NUM_SRC-1:0] ARITH_MASK = 9'h1E0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } calc_state_t;

  // Reorder raw switches so that source index equals command code.
  function automatic logic [NUM_SRC-1:0] map_sources(input logic [3:0] sel,
                                                     input logic [4:0] arith);
    return {arith[1], arith[2], arith[3], arith[4], sel, arith[0]};
  endfunction

  // Fixed priority: lowest set index wins.
  function automatic logic [CMD_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [CMD_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = CMD_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/calc_cmd_scheduler_if.sv
// Command channel between the scheduler (master) and the arithmetic datapath (slave).
interface calc_cmd_scheduler_if;
  import calc_cmd_scheduler_pkg::*;

  // A command transfers on any clock edge where cmd_valid & cmd_ready; once
  // cmd_valid rises, cmd_valid and cmd_code hold until that transfer, and
  // cmd_ready may be driven independently of cmd_valid.
  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_code;
  logic             cmd_ready;
  logic             op_done;
  logic             busy;
  logic             dropped;
  logic             timeout;

  modport master (
    output cmd_valid, cmd_code, busy, dropped, timeout,
    input  cmd_ready, op_done
  );

  modport slave (
    input  cmd_valid, cmd_code, busy, dropped, timeout,
    output cmd_ready, op_done
  );
endinterface

// File: rtl/calc_cmd_scheduler_debounce.sv
// Two-flop synchroniser plus level debouncer for one switch; emits a one-cycle
// pulse when the debounced level rises.
module calc_cmd_scheduler_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_100Mhz,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level;
  logic [CW-1:0] cnt;

  // The counter clears on every flip, so it never passes CNT_LAST.
  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_q2;
          cnt   <= '0;
          press <= sync_q2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calc_cmd_scheduler.sv
// Debounces nine switches into pending requests and issues them one at a time,
// lowest code first, holding off while an arithmetic op is running.
module calc_cmd_scheduler
  import calc_cmd_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset_n,
  input  logic [3:0]           sel_in,
  input  logic [4:0]           arithmetic_in,
  calc_cmd_scheduler_if.master cmd,
  output calc_state_t          state_dbg
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [NUM_SRC-1:0] raw_src;
  logic [NUM_SRC-1:0] press;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] clear_mask;
  logic [CMD_W-1:0]   code_q;
  logic [TW-1:0]      tcnt;
  calc_state_t        state;
  calc_state_t        state_n;
  logic               handshake;
  logic               load_code;
  logic               timeout_c;
  logic               dropped_c;

  assign raw_src = map_sources(sel_in, arithmetic_in);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    calc_cmd_scheduler_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock_100Mhz(clock_100Mhz),
      .reset_n     (reset_n),
      .raw         (raw_src[i]),
      .press       (press[i])
    );
  end

  assign handshake = (state == ST_ISSUE) && cmd.cmd_ready;

  // A press landing on a bit that is cleared this cycle is a fresh request, not a loss.
  always_comb begin
    grant      = '0;
    clear_mask = '0;
    if (handshake) begin
      grant      = NUM_SRC'(1) << code_q;
      clear_mask = grant | ((code_q == CMD_CLEAR) ? ARITH_MASK : '0);
    end
    pending_n = (pending & ~clear_mask) | press;
    dropped_c = |(press & pending & ~clear_mask);
  end

  always_comb begin
    state_n   = state;
    load_code = 1'b0;
    timeout_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          load_code = 1'b1;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          state_n = (code_q >= CMD_ADD) ? ST_WAIT_DONE : ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (cmd.op_done) begin
          state_n = ST_IDLE;
        end else if (tcnt == T_LAST) begin
          timeout_c = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pending <= '0;
      code_q  <= '0;
      tcnt    <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      if (load_code) code_q <= lowest_set(pending);
      // Counts only while staying in WAIT_DONE; entry from ISSUE starts at zero.
      if ((state == ST_WAIT_DONE) && (state_n == ST_WAIT_DONE)) begin
        tcnt <= (tcnt == T_LAST) ? tcnt : tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

  assign cmd.cmd_valid = (state == ST_ISSUE);
  assign cmd.cmd_code  = code_q;
  assign cmd.busy      = (state != ST_IDLE);
  assign cmd.dropped   = dropped_c;
  assign cmd.timeout   = timeout_c;
  assign state_dbg     = state;

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// Directed bench for calc_cmd_scheduler: stimulus pushes expected command codes,
// a negedge monitor pops and compares them at every handshake.
module tb_calc_cmd_scheduler;
  import calc_cmd_scheduler_pkg::*;

  logic        clock_100Mhz;
  logic        reset_n;
  logic [3:0]  sel_in;
  logic [4:0]  arithmetic_in;
  calc_state_t state_dbg;

  calc_cmd_scheduler_if cmd_if();

  calc_cmd_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset_n      (reset_n),
    .sel_in       (sel_in),
    .arithmetic_in(arithmetic_in),
    .cmd          (cmd_if),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock_100Mhz = 1'b0;
  always #5 clock_100Mhz = ~clock_100Mhz;

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int hs_count    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Negedge sees exactly what the next posedge will act on.
  logic [3:0] exp_code;
  always @(negedge clock_100Mhz) begin
    if (reset_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_cmd actual code=%0d required none at %0t",
                 cmd_if.cmd_code, $time);
      end else begin
        exp_code = exp_q.pop_front();
        check("cmd_code", cmd_if.cmd_code, exp_code);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_100Mhz);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_drain actual=%0d outstanding required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int i;
    i = 0;
    while (!cmd_if.cmd_valid && i < budget) begin
      tick(1);
      i++;
    end
    check({name, "_valid_seen"}, cmd_if.cmd_valid, 1);
  endtask

  task automatic pulse_op_done();
    cmd_if.op_done = 1'b1;
    tick(1);
    cmd_if.op_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int h0;
  int bad;
  int drops;
  int first_to;
  int to_cycles;

  initial begin
    reset_n          = 1'b0;
    sel_in           = '0;
    arithmetic_in    = '0;
    cmd_if.cmd_ready = 1'b0;
    cmd_if.op_done   = 1'b0;
    tick(3);
    check("reset_outputs",
          {cmd_if.cmd_valid, cmd_if.busy, cmd_if.dropped, cmd_if.timeout, cmd_if.cmd_code}, 0);
    check("reset_state", state_dbg, ST_IDLE);
    reset_n = 1'b1;
    tick(2);
    check("post_reset_idle", {cmd_if.cmd_valid, cmd_if.busy}, 0);

    // 1: bouncing digit-1 switch gives one command; re-press gives another
    cmd_if.cmd_ready = 1'b1;
    h0 = hs_count;
    exp_q.push_back(CMD_DIGIT1);
    sel_in = 4'b0001; tick(1);
    sel_in = 4'b0000; tick(1);
    sel_in = 4'b0001; tick(1);
    sel_in = 4'b0000; tick(1);
    sel_in = 4'b0001;
    wait_drain(30, "t1_first");
    tick(20);
    check("t1_held_once", hs_count - h0, 1);
    sel_in = 4'b0000;
    tick(10);
    exp_q.push_back(CMD_DIGIT1);
    sel_in = 4'b0001;
    wait_drain(30, "t1_repress");
    sel_in = 4'b0000;
    tick(10);
    check("t1_total", hs_count - h0, 2);

    // 2: add and digit-2 together -> digit 2 first, then add; busy until op_done
    h0 = hs_count;
    exp_q.push_back(CMD_DIGIT2);
    exp_q.push_back(CMD_ADD);
    sel_in        = 4'b0010;
    arithmetic_in = 5'b10000;
    wait_drain(40, "t2");
    tick(3);
    check("t2_busy_wait", cmd_if.busy, 1);
    check("t2_state_wait", state_dbg, ST_WAIT_DONE);
    sel_in        = '0;
    arithmetic_in = '0;
    tick(2);
    pulse_op_done();
    check("t2_busy_done", cmd_if.busy, 0);
    tick(10);
    check("t2_total", hs_count - h0, 2);

    // 3: sub held off by cmd_ready=0; re-press is dropped; one sub issued
    cmd_if.cmd_ready = 1'b0;
    arithmetic_in    = 5'b01000;
    wait_valid(30, "t3");
    check("t3_code", cmd_if.cmd_code, CMD_SUB);
    bad   = 0;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) arithmetic_in = 5'b00000;
      if (i == 8) arithmetic_in = 5'b01000;
      tick(1);
      if (!cmd_if.cmd_valid || cmd_if.cmd_code != CMD_SUB) bad++;
      if (cmd_if.dropped) drops++;
    end
    check("t3_stable", bad, 0);
    check("t3_dropped_once", drops, 1);
    h0 = hs_count;
    exp_q.push_back(CMD_SUB);
    cmd_if.cmd_ready = 1'b1;
    wait_drain(5, "t3");
    arithmetic_in = '0;
    pulse_op_done();
    tick(12);
    check("t3_one_sub", hs_count - h0, 1);

    // 4: div running, mul pressed meanwhile; mul only after op_done plus an idle cycle
    exp_q.push_back(CMD_DIV);
    arithmetic_in = 5'b00010;
    wait_drain(30, "t4_div");
    exp_q.push_back(CMD_MUL);
    arithmetic_in = 5'b00100;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (cmd_if.cmd_valid) bad++;
    end
    check("t4_no_overlap", bad, 0);
    pulse_op_done();
    check("t4_idle_gap", {cmd_if.cmd_valid, 2'(state_dbg)}, {1'b0, 2'(ST_IDLE)});
    wait_drain(10, "t4_mul");
    arithmetic_in = '0;
    pulse_op_done();
    tick(10);

    // 5: add with no op_done -> timeout in the 16th cycle after the handshake
    exp_q.push_back(CMD_ADD);
    arithmetic_in = 5'b10000;
    wait_drain(30, "t5");
    first_to  = 0;
    to_cycles = 0;
    for (int c = 1; c <= 24; c++) begin
      if (cmd_if.timeout) begin
        to_cycles++;
        if (first_to == 0) first_to = c;
      end
      tick(1);
    end
    check("t5_timeout_cycle", first_to, 16);
    check("t5_timeout_width", to_cycles, 1);
    check("t5_after", {cmd_if.busy, 2'(state_dbg)}, {1'b0, 2'(ST_IDLE)});
    arithmetic_in = '0;
    tick(10);

    // 6: reset during WAIT_DONE with sub pending abandons everything
    exp_q.push_back(CMD_ADD);
    arithmetic_in = 5'b10000;
    wait_drain(30, "t6_add");
    arithmetic_in = 5'b01000;
    tick(10);
    check("t6_busy_before", cmd_if.busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6_reset_outputs",
          {cmd_if.cmd_valid, cmd_if.busy, cmd_if.dropped, cmd_if.timeout, cmd_if.cmd_code}, 0);
    check("t6_reset_state", state_dbg, ST_IDLE);
    arithmetic_in = '0;
    tick(3);
    reset_n = 1'b1;
    h0 = hs_count;
    tick(20);
    check("t6_no_replay", hs_count - h0, 0);
    check("t6_valid_low", cmd_if.cmd_valid, 0);
    exp_q.push_back(CMD_SUB);
    arithmetic_in = 5'b01000;
    wait_drain(30, "t6_sub");
    arithmetic_in = '0;
    pulse_op_done();
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=expired required=finish");
    $fatal(1, "watchdog");
  end

endmodule
